// File: rtl/map_writer.sv
// map_writer: fills three circle-membership bitmaps, one grid address per clock,
// all three maps written in parallel, then pulses done.
module map_writer #(
    parameter int COORD_W   = 4,
    parameter int GRID_LOG2 = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [6*COORD_W-1:0]     central,
    input  logic [3*COORD_W-1:0]     radius,
    output logic                     wr_en,
    output logic [2*GRID_LOG2-1:0]   wr_addr,
    output logic [2:0]               wr_data,
    output logic                     busy,
    output logic                     done
);
    localparam int CW = COORD_W;
    localparam int GL = GRID_LOG2;
    localparam int AW = 2*GRID_LOG2;

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t            r_state, w_state;
    logic [AW-1:0]     r_cnt, w_cnt;
    logic [6*CW-1:0]   r_central, w_central;
    logic [3*CW-1:0]   r_radius, w_radius;
    logic              r_wr_en, w_wr_en;
    logic [AW-1:0]     r_wr_addr, w_wr_addr;
    logic [2:0]        r_wr_data, w_wr_data;
    logic              r_busy, w_busy;
    logic              r_done, w_done;
    logic [2:0]        w_in;

    // Grid point is 1-based; squares are taken on |d| so they stay unsigned.
    function automatic logic hit(input logic [AW-1:0] a, input logic [CW-1:0] cx,
                                 input logic [CW-1:0] cy, input logic [CW-1:0] r);
        logic [CW:0]     dx, dy;
        logic [CW-1:0]   ax, ay;
        logic [2*CW-1:0] sx, sy, r2;
        dx = (CW+1)'(a[GL-1:0]) + (CW+1)'(1) - {1'b0, cx};
        dy = (CW+1)'(a[AW-1:GL]) + (CW+1)'(1) - {1'b0, cy};
        ax = dx[CW] ? CW'(-dx) : dx[CW-1:0];
        ay = dy[CW] ? CW'(-dy) : dy[CW-1:0];
        sx = {{CW{1'b0}}, ax} * {{CW{1'b0}}, ax};
        sy = {{CW{1'b0}}, ay} * {{CW{1'b0}}, ay};
        r2 = {{CW{1'b0}}, r} * {{CW{1'b0}}, r};
        return ({1'b0, sx} + {1'b0, sy}) <= {1'b0, r2};
    endfunction

    for (genvar i = 0; i < 3; i++) begin : g_hit
        assign w_in[i] = hit(r_cnt,
                             r_central[(6-2*i)*CW-1 -: CW],
                             r_central[(5-2*i)*CW-1 -: CW],
                             r_radius[(3-i)*CW-1 -: CW]);
    end

    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_central = r_central;
        w_radius  = r_radius;
        w_wr_en   = r_wr_en;
        w_wr_addr = r_wr_addr;
        w_wr_data = r_wr_data;
        w_busy    = r_busy;
        w_done    = 1'b0;
        unique case (r_state)
            IDLE: begin
                // The cycle showing done still counts as part of the fill, so en is dropped there.
                if (en && !r_done) begin
                    w_central = central;
                    w_radius  = radius;
                    w_cnt     = '0;
                    w_busy    = 1'b1;
                    w_state   = WRITE;
                end
            end
            WRITE: begin
                w_wr_en   = 1'b1;
                w_wr_addr = r_cnt;
                w_wr_data = w_in;
                w_cnt     = r_cnt + AW'(1);
                w_state   = (r_cnt == '1) ? DONE : WRITE;
            end
            DONE: begin
                w_wr_en = 1'b0;
                w_done  = 1'b1;
                w_busy  = 1'b0;
                w_state = IDLE;
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_central <= '0;
            r_radius  <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_central <= w_central;
            r_radius  <= w_radius;
            r_wr_en   <= w_wr_en;
            r_wr_addr <= w_wr_addr;
            r_wr_data <= w_wr_data;
            r_busy    <= w_busy;
            r_done    <= w_done;
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign busy    = r_busy;
    assign done    = r_done;
endmodule
